rank_accum: RTL and testbench
=============================

RANK_ACCUM -- requirements
Module: rank_accum

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each unsigned fixed-point contribution and of the sum.
REQ-002 Parameter CNT_W, default 8: width of the term counter and of n_terms.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins an accumulation when sampled in IDLE.
REQ-006 n_terms  input  CNT_W  number of contributions to sum; sampled with start.
REQ-007 in_valid  input  1  in_data carries a contribution.
REQ-008 in_data  input  WIDTH  contribution value (unsigned).
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_sum and overflow are final.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  WIDTH  accumulated sum.
REQ-013 overflow  output  1  sticky flag: a carry out of bit WIDTH-1 occurred during this accumulation.

Function
REQ-014 The adder SHALL be a WIDTH-bit ripple-carry chain of the team's full-adder cells: carry-in 0, operands acc and in_data; the final cell's carry out is the overflow carry.
REQ-015 FSM states SHALL be IDLE, ACCUM and DONE; one state per cycle.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 SHALL load remaining<=n_terms, clear acc and overflow, and go to ACCUM, or go to DONE if n_terms=0.
REQ-017 ACCUM: in_ready=1; a beat transfers when in_valid & in_ready; each beat SHALL update acc<=sum, overflow<=overflow|carry and decrement remaining.
REQ-018 When the beat that takes remaining from 1 to 0 transfers, the next state SHALL be DONE, with the final sum visible on out_sum in that DONE cycle (one-cycle latency from last beat to out_valid).
REQ-019 Cycles in ACCUM with in_valid=0 SHALL leave acc, overflow and remaining unchanged.
REQ-020 DONE: in_ready=0, out_valid=1; out_sum and overflow SHALL stay constant until out_valid & out_ready, then the next state SHALL be IDLE.
REQ-021 start SHALL be ignored in ACCUM and DONE; start in the same cycle as a DONE handshake SHALL be ignored (a new run needs a start in IDLE).
REQ-022 in_valid outside ACCUM SHALL have no effect.
REQ-023 n_terms = 2^CNT_W-1 SHALL be supported without counter wrap.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, acc=0, remaining=0, overflow=0, in_ready=0, out_valid=0 and out_sum=0, independent of clk.
REQ-025 Reset asserted mid-accumulation SHALL discard the partial sum; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-026 Macro RANK_ACCUM_SAT_EN defined: on any beat whose carry is 1, acc SHALL become all-ones and stay all-ones for the rest of the run; overflow is still set.
REQ-027 Macro RANK_ACCUM_SAT_EN undefined: acc SHALL wrap modulo 2^WIDTH; overflow is still set.

Verification
REQ-028 Basic run: WIDTH=16, start with n_terms=3, beats 0x0010, 0x0020, 0x0030 with in_valid held high -> out_valid 1 cycle after the 3rd beat, out_sum=0x0060, overflow=0.
REQ-029 Zero terms and backpressure: start with n_terms=0 -> DONE next cycle with out_sum=0; out_ready held low 5 cycles -> out_valid and out_sum stable; out_ready=1 -> IDLE next cycle.
REQ-030 Overflow: n_terms=2, beats 0xFFFF and 0x0002 -> overflow=1, out_sum=0xFFFF with RANK_ACCUM_SAT_EN defined, 0x0001 without it.
REQ-031 Bubbles and ignored start: n_terms=2 with in_valid gaps and start pulsed during ACCUM -> sum of the 2 valid beats only, remaining unaffected by start.
REQ-032 Reset mid-run: rst_n pulsed low after 1 of 4 beats -> all outputs 0 immediately; a new start with n_terms=1 and beat 0x0005 -> out_sum=0x0005.

Source files
------------

// File: rtl/rank_accum.sv
// rank_accum: sums n_terms unsigned WIDTH-bit contributions into one result with a sticky overflow flag.
// Latency: one cycle from the last accepted beat to out_valid; a zero-term run reaches DONE one cycle after start.
// Backpressure: in_ready is high only in ACCUM; the result holds in DONE until out_valid & out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, n_terms       start pulse (honoured only in IDLE) and number of terms sampled with it
//   in_valid/in_ready    contribution handshake, in_data is the contribution
//   out_valid/out_ready  result handshake, out_sum and overflow are final while out_valid is high
// Build option: define RANK_ACCUM_SAT_EN to saturate the sum at all-ones on overflow
// instead of wrapping modulo 2^WIDTH.

// Single-bit full-adder cell used to build the ripple-carry chain.
module rank_accum_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module rank_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_overflow;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_beat;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_acc_nxt;

    // Ripple-carry adder: acc + in_data, carry-in tied low; top carry is the overflow carry.
    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        rank_accum_fa u_fa (
            .i_a  (r_acc[g]),
            .i_b  (in_data[g]),
            .i_ci (w_carry[g]),
            .o_s  (w_sum[g]),
            .o_co (w_carry[g+1])
        );
    end

`ifdef RANK_ACCUM_SAT_EN
    // Once any beat of this run has carried out, the sum is pinned at all-ones
    // for the rest of the run.
    assign w_acc_nxt = (w_carry[WIDTH] | r_overflow) ? {WIDTH{1'b1}} : w_sum;
`else
    assign w_acc_nxt = w_sum;
`endif

    // A beat only exists in ACCUM; in_valid anywhere else is ignored.
    assign w_beat = w_in_ready & in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (n_terms == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                // Last beat moves straight to DONE so the registered sum shows next cycle.
                if (in_valid && (r_remaining == CNT_W'(1))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counter counts down from n_terms, so the full 2^CNT_W-1 range never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_acc       <= '0;
            r_remaining <= n_terms;
            r_overflow  <= 1'b0;
        end else if (w_beat) begin
            r_acc       <= w_acc_nxt;
            r_remaining <= r_remaining - CNT_W'(1);
            r_overflow  <= r_overflow | w_carry[WIDTH];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_sum   = r_acc;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_rank_accum.sv
// tb_rank_accum: randomized and directed runs of rank_accum against a whole-run arithmetic model.
// Latency: expects out_valid one cycle after the last beat, IDLE one cycle after the result handshake.
// Backpressure: holds out_ready low for a random number of DONE cycles and checks the result stays put.
module tb_rank_accum;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    // Directed contributions consumed (in order) by the next run's valid beats.
    logic [WIDTH-1:0] plan[$];

    always #5 clk = ~clk;

    rank_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_terms   (n_terms),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_data();
        logic [WIDTH-1:0] d;
        case ($urandom_range(3))
            0:       d = WIDTH'($urandom_range(255));
            1:       d = WIDTH'($urandom_range(MAXV, MAXV - 4095));
            2:       d = WIDTH'($urandom);
            default: d = ($urandom_range(1) == 1) ? WIDTH'(MAXV) : '0;
        endcase
        return d;
    endfunction

    // Model of a whole run: any carry happened iff the true total exceeds the
    // WIDTH-bit range; the result is then either the wrapped total or all-ones.
    function automatic logic [WIDTH-1:0] model_sum(input int total);
`ifdef RANK_ACCUM_SAT_EN
        return (total > MAXV) ? WIDTH'(MAXV) : WIDTH'(total);
`else
        return WIDTH'(total);
`endif
    endfunction

    // One complete run. Called with inputs driven just after a rising edge (or
    // mid-cycle) and with the DUT in IDLE; returns the same way, DUT in IDLE.
    task automatic do_run(input int n, input int gap_pct, input int bp, input bit noise);
        int               total = 0;
        int               sent  = 0;
        int               cyc   = 0;
        bit               v;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] es;
        bit               eovf;

        start    = 1'b1;
        n_terms  = CNT_W'(n);
        in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        in_data  = rand_data();
        @(posedge clk); #1;
        start = 1'b0;

        while (sent < n) begin
            v = (cyc > 3 * n) || (int'($urandom_range(99)) >= gap_pct);
            if (v && plan.size() > 0) d = plan.pop_front();
            else d = rand_data();
            in_valid = v;
            in_data  = d;
            if (noise) begin
                start   = ($urandom_range(3) == 0);
                n_terms = CNT_W'($urandom);
            end
            @(negedge clk);
            chk("accum_in_ready", 32'(in_ready), 32'd1);
            chk("accum_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            if (v) begin
                total += int'(d);
                sent++;
            end
            cyc++;
        end

        in_valid = 1'b0;
        start    = 1'b0;
        es   = model_sum(total);
        eovf = (total > MAXV);

        for (int i = 0; i <= bp; i++) begin
            out_ready = (i == bp);
            if (noise) begin
                in_valid = 1'($urandom_range(1));
                in_data  = rand_data();
                start    = 1'($urandom_range(1));
                if (i == bp) start = 1'b1;
            end
            @(negedge clk);
            chk("done_out_valid", 32'(out_valid), 32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_out_sum", 32'(out_sum), 32'(es));
            chk("done_overflow", 32'(overflow), 32'(eovf));
            @(posedge clk); #1;
        end

        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = noise ? 1'($urandom_range(1)) : 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        n_terms   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic three-beat run.
        plan = '{16'h0010, 16'h0020, 16'h0030};
        do_run(3, 0, 0, 1'b0);

        // Zero terms with 5 cycles of backpressure.
        do_run(0, 0, 5, 1'b0);

        // Carry out of the top bit.
        plan = '{16'hFFFF, 16'h0002};
        do_run(2, 0, 1, 1'b0);

        // Bubbles plus start/n_terms noise during the run.
        plan = '{16'h0007, 16'h0009};
        do_run(2, 60, 2, 1'b1);

        // Reset after 1 of 4 beats: outputs drop without waiting for a clock edge.
        start    = 1'b1;
        n_terms  = CNT_W'(4);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0064;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_sum", 32'(out_sum), 32'h64);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sum", 32'(out_sum), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("postrst_in_ready", 32'(in_ready), 32'd0);
            chk("postrst_out_sum", 32'(out_sum), 32'd0);
        end
        in_valid = 1'b0;
        plan = '{16'h0005};
        do_run(1, 0, 0, 1'b0);

        // Largest term count the counter can hold.
        do_run((1 << CNT_W) - 1, 10, 0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            do_run(int'($urandom_range(12)), 30, int'($urandom_range(3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
